m_div_seq: RTL and testbench

Iterative radix-2 integer divider for the RV64M divide/remainder group (DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW). It sits directly downstream of the M-extension ALU's operand and opcode decode. The M ALU issues one operation via `start_i` and holds `stall_o` while `busy_o` is high. It then muxes `result_o` into `alu_result_oa` on the cycle `done_o` is high.

---
 rtl/m_div_seq_pkg.sv | 40 ++++
 rtl/m_div_seq_step.sv | 23 ++
 rtl/m_div_seq.sv | 133 +++++++++++++
 tb/tb_m_div_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/m_div_seq_pkg.sv
// Shared types and opcode decode for the sequential RV64M divider.
package m_div_seq_pkg;

  localparam logic [5:0] ALU_OP_DIV   = 6'h20;
  localparam logic [5:0] ALU_OP_DIVU  = 6'h21;
  localparam logic [5:0] ALU_OP_REM   = 6'h22;
  localparam logic [5:0] ALU_OP_REMU  = 6'h23;
  localparam logic [5:0] ALU_OP_DIVW  = 6'h24;
  localparam logic [5:0] ALU_OP_DIVUW = 6'h25;
  localparam logic [5:0] ALU_OP_REMW  = 6'h26;
  localparam logic [5:0] ALU_OP_REMUW = 6'h27;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} div_state_e;

  typedef struct packed {
    logic valid;
    logic sgn;
    logic rem;
    logic word;
  } div_flags_t;

  function automatic div_flags_t decode_op(input logic [5:0] op);
    div_flags_t f;
    f = '0;
    f.valid = 1'b1;
    case (op)
      ALU_OP_DIV:   f.sgn = 1'b1;
      ALU_OP_DIVU:  ;
      ALU_OP_REM:   begin f.sgn = 1'b1; f.rem = 1'b1; end
      ALU_OP_REMU:  f.rem = 1'b1;
      ALU_OP_DIVW:  begin f.sgn = 1'b1; f.word = 1'b1; end
      ALU_OP_DIVUW: f.word = 1'b1;
      ALU_OP_REMW:  begin f.sgn = 1'b1; f.rem = 1'b1; f.word = 1'b1; end
      ALU_OP_REMUW: begin f.rem = 1'b1; f.word = 1'b1; end
      default:      f.valid = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/m_div_seq_step.sv
// One restoring division step: shift {rem,quo} left, trial-subtract divisor.
module m_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] shf;
  logic [XLEN:0] dif;
  logic          ge;

  assign shf = {rem, quo[XLEN-1]};
  assign dif = shf - {1'b0, dvs};
  // rem < dvs on entry, so the top bit of the 65-bit difference is an exact borrow
  assign ge      = ~dif[XLEN];
  assign rem_nxt = ge ? dif[XLEN-1:0] : shf[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], ge};

endmodule

// File: rtl/m_div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
module m_div_seq
  import m_div_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [5:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  div_state_e state_q, state_d;
  div_flags_t dec;

  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic [XLEN-1:0] quo_nxt, rem_nxt;
  logic [5:0]      cnt_q;
  logic            op_rem_q, op_word_q, qneg_q, rneg_q, spec_q;

  logic            launch, sa, sb, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [31:0]     a_neg32, b_neg32;
  logic [XLEN-1:0] q_fix, r_fix, sel, fix_res;

  assign dec    = decode_op(op_i);
  assign launch = (state_q == S_IDLE) && start_i && !kill_i && dec.valid;

  assign sa      = dec.sgn & (dec.word ? a_i[31] : a_i[XLEN-1]);
  assign sb      = dec.sgn & (dec.word ? b_i[31] : b_i[XLEN-1]);
  assign a_neg32 = 32'd0 - a_i[31:0];
  assign b_neg32 = 32'd0 - b_i[31:0];
  assign a_mag   = dec.word ? {32'd0, sa ? a_neg32 : a_i[31:0]} : (sa ? '0 - a_i : a_i);
  assign b_mag   = dec.word ? {32'd0, sb ? b_neg32 : b_i[31:0]} : (sb ? '0 - b_i : b_i);

  assign div0 = dec.word ? (b_i[31:0] == 32'd0) : (b_i == '0);
  assign ovf  = dec.sgn & (dec.word ? (a_i[31:0] == 32'h8000_0000 && b_i[31:0] == 32'hFFFF_FFFF)
                                    : (a_i == {1'b1, {(XLEN-1){1'b0}}} && b_i == '1));

  m_div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Special-case results are preloaded raw, so sign correction is bypassed for them
  assign q_fix   = (!spec_q && qneg_q) ? '0 - quo_q : quo_q;
  assign r_fix   = (!spec_q && rneg_q) ? '0 - rem_q : rem_q;
  assign sel     = op_rem_q ? r_fix : q_fix;
  assign fix_res = op_word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: if (launch) state_d = (div0 || ovf) ? S_FIX : S_CALC;
      S_CALC: begin
        busy_o = 1'b1;
        if (cnt_q == 6'd0) state_d = S_FIX;
      end
      S_FIX: begin
        busy_o  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      op_rem_q  <= 1'b0;
      op_word_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      spec_q    <= 1'b0;
      result_o  <= '0;
    end else if (!kill_i) begin
      case (state_q)
        S_IDLE: if (launch) begin
          op_rem_q  <= dec.rem;
          op_word_q <= dec.word;
          qneg_q    <= sa ^ sb;
          rneg_q    <= sa;
          dvs_q     <= b_mag;
          cnt_q     <= dec.word ? 6'd31 : 6'd63;
          spec_q    <= div0 | ovf;
          if (div0) begin
            quo_q <= '1;
            rem_q <= a_i;
          end else if (ovf) begin
            quo_q <= a_i;
            rem_q <= '0;
          end else begin
            // W dividend sits in the top half so its MSB shifts out first
            quo_q <= dec.word ? {a_mag[31:0], 32'd0} : a_mag;
            rem_q <= '0;
          end
        end
        S_CALC: begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q - 6'd1;
        end
        S_FIX:   result_o <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m_div_seq.sv
// Randomized scoreboard bench for m_div_seq against an arithmetic reference model.
module tb_m_div_seq;
  import m_div_seq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [5:0]  op_i = '0;
  logic [63:0] a_i = '0;
  logic [63:0] b_i = '0;
  logic        busy_o, done_o;
  logic [63:0] result_o;

  m_div_seq #(.XLEN(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .kill_i(kill_i),
    .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          s;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] last_res = '0;

  localparam logic [5:0] OPS [8] = '{ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU,
                                     ALU_OP_DIVW, ALU_OP_DIVUW, ALU_OP_REMW, ALU_OP_REMUW};

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [63:0] model(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                                        output int lat);
    bit w, s, r, sp;
    logic [63:0] q, rm, res;
    longint sa, sb;
    int sa32, sb32;
    logic [31:0] x, y, q32, r32;
    w  = op inside {ALU_OP_DIVW, ALU_OP_DIVUW, ALU_OP_REMW, ALU_OP_REMUW};
    s  = op inside {ALU_OP_DIV, ALU_OP_REM, ALU_OP_DIVW, ALU_OP_REMW};
    r  = op inside {ALU_OP_REM, ALU_OP_REMU, ALU_OP_REMW, ALU_OP_REMUW};
    sp = 1'b0;
    if (!w) begin
      sa = a; sb = b;
      if (b == 0) begin q = '1; rm = a; sp = 1'b1; end
      else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; rm = 0; sp = 1'b1; end
      else if (s) begin q = sa / sb; rm = sa % sb; end
      else begin q = a / b; rm = a % b; end
      res = r ? rm : q;
    end else begin
      x = a[31:0]; y = b[31:0]; sa32 = x; sb32 = y;
      if (y == 0) begin q32 = '1; r32 = x; sp = 1'b1; end
      else if (s && x == 32'h8000_0000 && y == '1) begin q32 = x; r32 = 0; sp = 1'b1; end
      else if (s) begin q32 = sa32 / sb32; r32 = sa32 % sb32; end
      else begin q32 = x / y; r32 = x % y; end
      res = r ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end
    lat = sp ? 2 : (w ? 34 : 66);
    return res;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: result %h with no pending op", result_o);
      end else begin
        exp_t e;
        e = expq.pop_front();
        checks++;
        if (result_o !== e.res) begin
          errors++;
          $display("FAIL result: got %h expected %h", result_o, e.res);
        end
        checks++;
        if (cyc - e.s + 1 != e.lat) begin
          errors++;
          $display("FAIL latency: got %0d expected %0d", cyc - e.s + 1, e.lat);
        end
      end
    end
  end

  task automatic run_op(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b, input bit hold);
    exp_t e;
    int   lat;
    bit   seen;
    @(negedge clk_i);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    e.res = model(op, a, b, lat);
    e.lat = lat;
    e.s   = cyc;
    expq.push_back(e);
    last_res = e.res;
    start_i = hold;
    a_i = {$urandom(), $urandom()};
    b_i = {$urandom(), $urandom()};
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
    end
    start_i = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout: op %h never signalled done", op);
    end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 10))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      5: return 64'hFFFF_FFFF_8000_0000;
      6: return 64'h0000_0000_7FFF_FFFF;
      7: return 64'($urandom_range(0, 255));
      8: return 64'd0 - 64'($urandom_range(1, 100));
      9: return {32'd0, $urandom()};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk_i);
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_done", {63'd0, done_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst_i = 1'b0;

    // Directed cases; the first holds start_i high while busy
    run_op(ALU_OP_DIVU, 64'd100, 64'd7, 1'b1);
    run_op(ALU_OP_REMU, 64'd100, 64'd7, 1'b0);
    run_op(ALU_OP_DIV, -64'sd7, 64'd2, 1'b0);
    run_op(ALU_OP_REM, -64'sd7, 64'd2, 1'b0);
    run_op(ALU_OP_DIV, 64'h8000_0000_0000_0000, '1, 1'b0);
    run_op(ALU_OP_REMU, 64'd12345, 64'd0, 1'b0);
    run_op(ALU_OP_DIVU, 64'd12345, 64'd0, 1'b0);
    run_op(ALU_OP_DIVUW, 64'hFFFF_FFFF_8000_0000, 64'd1, 1'b0);
    run_op(ALU_OP_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0);
    run_op(ALU_OP_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b0);

    // Kill mid-CALC
    @(negedge clk_i);
    op_i = ALU_OP_DIVU; a_i = 64'd100; b_i = 64'd7; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    kill_i = 1'b1;
    @(posedge clk_i); #1 kill_i = 1'b0;
    chk("kill_busy", {63'd0, busy_o}, 64'd0);
    chk("kill_done", {63'd0, done_o}, 64'd0);
    chk("kill_result", result_o, last_res);
    repeat (80) @(negedge clk_i);
    chk("kill_idle_busy", {63'd0, busy_o}, 64'd0);

    // Start together with kill is refused
    @(negedge clk_i);
    start_i = 1'b1; kill_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0; kill_i = 1'b0;
    chk("start_kill_busy", {63'd0, busy_o}, 64'd0);

    // Non-divide opcode is ignored
    @(negedge clk_i);
    op_i = 6'h3F; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    chk("bad_op_busy", {63'd0, busy_o}, 64'd0);
    repeat (5) @(negedge clk_i);

    // Reset mid-CALC clears outputs immediately
    @(negedge clk_i);
    op_i = ALU_OP_DIV; a_i = 64'd999; b_i = 64'd3; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (20) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    @(negedge clk_i) rst_i = 1'b0;
    last_res = '0;

    for (int n = 0; n < 1000; n++)
      run_op(OPS[$urandom_range(0, 7)], pick(), pick(), $urandom_range(0, 3) == 0);

    repeat (5) @(negedge clk_i);
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
